// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared display constants: converter FSM encoding and BCD digit geometry,
// also used by the BCD-to-seven-segment stage.
package bin_to_bcd_seq_pkg;

  localparam int BCD_W      = 4;
  localparam int BCD_DIGITS = 3;
  localparam int STATE_W    = 1;

  localparam logic [STATE_W-1:0] ST_IDLE    = 1'b0;
  localparam logic [STATE_W-1:0] ST_CONVERT = 1'b1;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_add3_digit
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_W'(5)) digit_o = digit_i + BCD_W'(3);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// sign extraction, feeding the seven-segment display stage.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit SIGNED     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  negative,
  output logic [BCD_W-1:0]      bcd_hundreds,
  output logic [BCD_W-1:0]      bcd_tens,
  output logic [BCD_W-1:0]      bcd_units,
  output logic [STATE_W-1:0]    dbg_state
);

  localparam int DIG_W = BCD_DIGITS * BCD_W;
  localparam int SCR_W = DIG_W + DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  // Handshake: start is sampled only while busy=0; done pulses for one cycle
  // with busy=0 and new outputs, so a start in the done cycle is accepted.

  logic [STATE_W-1:0] state_q, state_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               done_q, done_d;
  logic               neg_q, neg_d;
  logic [DIG_W-1:0]   bcd_q, bcd_d;

  logic [DATA_WIDTH:0] mag_full;
  logic [DIG_W-1:0]    corr;
  logic [SCR_W-1:0]    step;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (scratch_q[DATA_WIDTH + g*BCD_W +: BCD_W]),
      .digit_o (corr[g*BCD_W +: BCD_W])
    );
  end

  // The magnitude's top bit is always 0 for in-range inputs, so loading it
  // into the units LSB leaves the digit field numerically zero.
  always_comb begin
    mag_full = {1'b0, data_in};
    if (SIGNED && data_in[DATA_WIDTH-1]) mag_full = -{data_in[DATA_WIDTH-1], data_in};
    step = {corr, scratch_q[DATA_WIDTH-1:0]} << 1;
  end

  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    done_d    = 1'b0;
    neg_d     = neg_q;
    bcd_d     = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CONVERT;
          scratch_d = SCR_W'(mag_full);
          cnt_d     = CNT_W'(DATA_WIDTH);
          sign_d    = SIGNED && data_in[DATA_WIDTH-1];
        end
      end
      ST_CONVERT: begin
        scratch_d = step;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          neg_d   = sign_q;
          bcd_d   = step[SCR_W-1 -: DIG_W];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      scratch_q <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      done_q    <= 1'b0;
      neg_q     <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      done_q    <= done_d;
      neg_q     <= neg_d;
      bcd_q     <= bcd_d;
    end
  end

  assign busy         = (state_q == ST_CONVERT);
  assign done         = done_q;
  assign negative     = neg_q;
  assign bcd_hundreds = bcd_q[2*BCD_W +: BCD_W];
  assign bcd_tens     = bcd_q[BCD_W +: BCD_W];
  assign bcd_units    = bcd_q[0 +: BCD_W];
  assign dbg_state    = state_q;

endmodule
